alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand and result width; legal values are 11 or greater.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 each, meaning requester k presents an operation.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 each, meaning the operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_ctrl and req1_ctrl, input, 4 each, meaning the ALU operation code.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, DATA_W each, meaning the operands.
REQ-008 The block SHALL have port rsp_valid, output, 1, meaning a result is present this cycle (single-cycle pulse, no backpressure).
REQ-009 The block SHALL have port rsp_id, output, 1, meaning the index of the requester that owns the result.
REQ-010 The block SHALL have port rsp_result, output, DATA_W, meaning the registered ALU result.
REQ-011 The block SHALL have port rsp_zero, output, 1, meaning rsp_result equals 0.

Function
REQ-012 The block SHALL share one ALU between two requesters and accept at most one operation per cycle.
REQ-013 A transfer on port k SHALL occur when reqk_valid and reqk_ready are both high; reqk_ready SHALL be combinational from the valids and the arbiter state.
REQ-014 reqk_ready SHALL be high only when reqk_valid is high and port k wins arbitration.
REQ-015 A requester SHALL hold valid, ctrl and operands stable until accepted; the block does not check this.
REQ-016 When only one valid is high, that port SHALL be accepted in the same cycle.
REQ-017 When both valids are high, arbitration SHALL follow REQ-031/REQ-032.
REQ-018 Register last_grant SHALL update to the accepted index on every transfer and SHALL otherwise hold its value.
REQ-019 A transfer in cycle N SHALL produce rsp_valid=1 in cycle N+1, with rsp_id equal to the accepted index and the rsp_result/rsp_zero values for that operation; latency is exactly 1.
REQ-020 rsp_valid SHALL be 0 in any cycle that follows a cycle without a transfer; rsp_result, rsp_id and rsp_zero SHALL hold their last values.
REQ-021 Op codes SHALL produce these results: 0010 a+b; 0110 a-b; 0000 a&b; 0001 a|b; 0111 is 1 if a<b (unsigned), else 0.
REQ-022 Op codes SHALL also produce: 0100 a shifted left logically by b[10:6]; 1000 a shifted right logically by b[10:6]; any other code 0.
REQ-023 Add and subtract SHALL wrap modulo 2^DATA_W; no carry or overflow output exists.
REQ-024 The block SHALL sustain back-to-back transfers every cycle with no bubble.

Reset
REQ-025 On rst_n low, rsp_valid, rsp_id, rsp_result and rsp_zero SHALL clear to 0 asynchronously.
REQ-026 On rst_n low, last_grant SHALL be set to 1, so that port 0 wins the first contention.
REQ-027 While rst_n is low, req0_ready and req1_ready SHALL be 0.
REQ-028 An operation accepted in the cycle in which reset asserts SHALL be discarded and SHALL produce no response.
REQ-029 Reset SHALL be released synchronously to clk by the system; the block adds no synchronizer.

Configuration
REQ-030 Macro ALU_ARB_RR_EN SHALL select the arbitration policy.
REQ-031 With ALU_ARB_RR_EN defined, contention SHALL be resolved round-robin: the port not equal to last_grant wins.
REQ-032 Without ALU_ARB_RR_EN, contention SHALL be resolved by fixed priority to port 0; last_grant is still maintained but unused.

Structure
REQ-033 A shared package SHALL hold the op-code constants (ADD, SUB, AND, OR, SLT, SLL, SRL) and the shift-field bounds 10:6.
REQ-034 The block SHALL contain one sub-module, alu_core: a combinational ALU implementing REQ-021 to REQ-023.
REQ-035 Arbitration and the response register SHALL reside in alu_arbiter.

Verification
REQ-036 Scenario: only req0 is valid with ctrl=0010, a=5, b=7 -> req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-037 Scenario: both ports held valid for 4 cycles, RR build -> grants 0,1,0,1 and responses with rsp_id 0,1,0,1 on consecutive cycles.
REQ-038 Scenario: the same stimulus as REQ-037, fixed-priority build -> port 0 is granted all 4 cycles and req1_ready stays 0.
REQ-039 Scenario: ctrl=0110 with a=3, b=3 -> rsp_result=0 and rsp_zero=1; ctrl=0110 with a=0, b=1 -> rsp_result=0xFFFFFFFF.
REQ-040 Scenario: ctrl=0100 with a=1, b=0x000000C0 -> 8; ctrl=1000 with a=0x80000000, b=0x7C0 -> 1; ctrl=0111 with a=2, b=0xFFFFFFFF -> 1; ctrl=1111 -> 0.
REQ-041 Scenario: a transfer in cycle N with rst_n asserted before edge N+1 -> no rsp_valid, all outputs 0, and port 0 wins the next contention.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter.
// Holds the ALU op-code encodings, the control width and the bit range of
// operand b that carries the shift amount.
package alu_arbiter_pkg;

    localparam int unsigned CTRL_W   = 4;
    localparam int unsigned SHAMT_HI = 10;
    localparam int unsigned SHAMT_LO = 6;
    localparam int unsigned SHAMT_W  = SHAMT_HI - SHAMT_LO + 1;

    // ALU op codes; any encoding not listed yields a zero result
    typedef enum logic [CTRL_W-1:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SLL = 4'b0100,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_SRL = 4'b1000
    } alu_op_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle of the shared ALU arbiter.
//   req0_*/req1_* : valid/ready handshake, op code and operands per requester
//   rsp_*         : one-cycle result pulse with owner id and zero flag
// Modports: master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
);

    logic              req0_valid;
    logic              req0_ready;
    logic [CTRL_W-1:0] req0_ctrl;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [CTRL_W-1:0] req1_ctrl;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_arbiter_alu_core.sv
// alu_core: purely combinational ALU shared by both requesters.
//   ctrl     : op code (see alu_arbiter_pkg)
//   a, b     : operands; shifts take their amount from b[SHAMT_HI:SHAMT_LO]
//   result_c : combinational result, add/sub wrap modulo 2^DATA_W
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result_c
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_HI:SHAMT_LO];

    // Op decode; unknown codes fall through to zero
    always_comb begin
        result_c = '0;
        case (ctrl)
            OP_ADD:  result_c = a + b;
            OP_SUB:  result_c = a - b;
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_SLT:  result_c = DATA_W'(a < b);
            OP_SLL:  result_c = a << shamt;
            OP_SRL:  result_c = a >> shamt;
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU; at most one
// operation is accepted per cycle and its result is returned one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_arbiter_if.slave (request handshakes, response pulse)
// Contention policy is chosen at build time by macro ALU_ARB_RR_EN:
//   defined   -> round robin (the port that did not win last time wins)
//   undefined -> fixed priority to port 0
// The ready outputs are combinational from the valids and last_grant.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    logic              grant0_c;
    logic              grant1_c;
    logic              xfer_c;
    logic              sel_c;
    logic [CTRL_W-1:0] op_ctrl_c;
    logic [DATA_W-1:0] op_a_c;
    logic [DATA_W-1:0] op_b_c;
    logic [DATA_W-1:0] alu_result_c;

    logic              last_grant;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;

    // Arbitration; nothing is granted while reset is asserted
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (rst_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
                grant0_c = last_grant;
                grant1_c = ~last_grant;
`else
                grant0_c = 1'b1;
`endif
            end else begin
                grant0_c = bus.req0_valid;
                grant1_c = bus.req1_valid;
            end
        end
    end

`ifndef ALU_ARB_RR_EN
    // last_grant is still tracked in the fixed-priority build, just not consumed
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    assign xfer_c = grant0_c | grant1_c;
    assign sel_c  = grant1_c;

    assign bus.req0_ready = grant0_c;
    assign bus.req1_ready = grant1_c;

    // Operand mux in front of the shared ALU
    assign op_ctrl_c = sel_c ? bus.req1_ctrl : bus.req0_ctrl;
    assign op_a_c    = sel_c ? bus.req1_a    : bus.req0_a;
    assign op_b_c    = sel_c ? bus.req1_b    : bus.req0_b;

    alu_core #(
        .DATA_W   (DATA_W)
    ) u_alu_core (
        .ctrl     (op_ctrl_c),
        .a        (op_a_c),
        .b        (op_b_c),
        .result_c (alu_result_c)
    );

    // Grant history; reset value 1 makes port 0 win the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (xfer_c) begin
            last_grant <= sel_c;
        end
    end

    // Response register: valid pulses once per transfer, payload holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            rsp_valid_q <= xfer_c;
            if (xfer_c) begin
                rsp_id_q     <= sel_c;
                rsp_result_q <= alu_result_c;
                rsp_zero_q   <= (alu_result_c == '0);
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;

endmodule
